// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// fwd_sel: operand-forwarding priority.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StFlushHold,
    StDrain,
    StHalted
  } ctrl_state_e;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic       ex_we,
                                         input logic [4:0] ex_rd,
                                         input logic       wb_we,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] src);
    if (ex_we && ex_rd != REG_ZERO && ex_rd == src) return FWD_MEM;
    if (wb_we && wb_rd != REG_ZERO && wb_rd == src) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage fields in, gating controls out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic [4:0]       idex_rs;
  logic [4:0]       idex_rt;
  logic             idex_mem_read;
  logic             exmem_reg_write;
  logic [4:0]       exmem_rd;
  logic             memwb_reg_write;
  logic [4:0]       memwb_rd;
  logic             branch_taken;
  logic             halt_req;
  logic             halt_ack;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_rs, idex_rt, idex_mem_read,
           exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, branch_taken, halt_req,
    input  halt_ack, pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
           fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_rs, idex_rt, idex_mem_read,
           exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, branch_taken, halt_req,
    output halt_ack, pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
           fwd_a, fwd_b, stall_count, flush_count
  );
endinterface

// File: rtl/fwd_unit.sv
// Combinational EX-stage forwarding select for both ALU operands.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic       exmem_reg_write_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       memwb_reg_write_i,
  input  logic [4:0] memwb_rd_i,
  input  logic [4:0] idex_rs_i,
  input  logic [4:0] idex_rt_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_sel(exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i,
                           idex_rs_i);
  assign fwd_b_o = fwd_sel(exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i,
                           idex_rt_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, forwarding, branch flush and
// a halt/drain handshake that freezes fetch until in-flight work retires.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES - 1);

  ctrl_state_e       state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              stall_inc, flush_inc, flush_all, load_use;

  fwd_unit u_fwd_unit (
    .exmem_reg_write_i(bus.exmem_reg_write),
    .exmem_rd_i       (bus.exmem_rd),
    .memwb_reg_write_i(bus.memwb_reg_write),
    .memwb_rd_i       (bus.memwb_rd),
    .idex_rs_i        (bus.idex_rs),
    .idex_rt_i        (bus.idex_rt),
    .fwd_a_o          (bus.fwd_a),
    .fwd_b_o          (bus.fwd_b)
  );

  assign load_use = bus.idex_mem_read && bus.idex_rt != REG_ZERO &&
                    (bus.idex_rt == bus.ifid_rs ||
                     (bus.ifid_uses_rt && bus.idex_rt == bus.ifid_rt));

  always_comb begin
    state_d         = state_q;
    drain_d         = drain_q;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    flush_all       = 1'b0;
    flush_inc       = 1'b0;
    stall_inc       = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.branch_taken) begin
          flush_all = 1'b1;
          flush_inc = 1'b1;
          state_d   = StFlushHold;
        end else if (bus.halt_req) begin
          state_d = StDrain;
          drain_d = DrainInit;
        end else if (load_use) begin
          bus.pc_write    = 1'b0;
          bus.ifid_write  = 1'b0;
          bus.idex_bubble = 1'b1;
          stall_inc       = 1'b1;
        end
      end
      StFlushHold: begin
        if (bus.halt_req) begin
          state_d = StDrain;
          drain_d = DrainInit;
        end else begin
          state_d = StRun;
        end
      end
      StDrain: begin
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.idex_bubble = 1'b1;
        if (drain_q != '0) drain_d = drain_q - DrainW'(1);
        // A late branch still squashes younger stages but delays the halt.
        if (bus.branch_taken) begin
          flush_all = 1'b1;
          flush_inc = 1'b1;
        end else if (!bus.halt_req) begin
          state_d = StRun;
        end else if (drain_q == '0) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.idex_bubble = 1'b1;
        if (!bus.halt_req) state_d = StRun;
      end
    endcase
  end

  assign bus.flush_ifid  = flush_all;
  assign bus.flush_idex  = flush_all;
  assign bus.flush_exmem = flush_all;
  assign bus.halt_ack    = (state_q == StHalted);
  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule
